lut_layer_sequencer: RTL

- Time-multiplexed evaluator for one LogicNets-style layer of single-bit LUT neurons.
- One shared FANIN-input truth-table store and one connectivity table are stepped across N_NEURONS neurons, one neuron per cycle.
- Results are gathered into an N_NEURONS-bit output vector.
- Sits between layer stages; ready/valid on both sides; run-time config port loads truth tables and connectivity.

---
 rtl/lut_seq_pkg.sv | 26 ++
 rtl/lut_seq_mem.sv | 54 +++++
 rtl/lut_layer_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lut_seq_pkg.sv
// Shared state encoding, config-select codes and width helpers for the LUT layer sequencer.
package lut_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } seq_state_e;

  localparam logic CFG_SEL_LUT  = 1'b0;
  localparam logic CFG_SEL_CONN = 1'b1;

  // An index is always at least one bit wide, even for a single entry.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  function automatic int conn_w(input int in_w);
    return clog2_min1(in_w);
  endfunction

  function automatic int nidx_w(input int n_neurons);
    return clog2_min1(n_neurons);
  endfunction

endpackage

// File: rtl/lut_seq_mem.sv
// Truth-table and connectivity storage plus the FANIN-way input gather for one neuron.
// Latency: writes land on the next clk edge; the result bit is combinational from rd_n/in_vec.
// Backpressure: none; the caller gates the write enables.
module lut_seq_mem
  import lut_seq_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter int CONN_W    = conn_w(IN_W),
  parameter int NIDX_W    = nidx_w(N_NEURONS),
  parameter int K_W       = clog2_min1(FANIN)
) (
  input  logic              clk,
  input  logic              lut_we,
  input  logic [NIDX_W-1:0] lut_n,
  input  logic [FANIN-1:0]  lut_bit,
  input  logic              lut_wdat,
  input  logic              conn_we,
  input  logic [NIDX_W-1:0] conn_n,
  input  logic [K_W-1:0]    conn_k,
  input  logic [CONN_W-1:0] conn_wdat,
  input  logic [NIDX_W-1:0] rd_n,
  input  logic [IN_W-1:0]   in_vec,
  output logic              res_bit
);

  // Neither array is reset: tables survive rst_n.
  logic [(1<<FANIN)-1:0] lut_mem  [N_NEURONS];
  logic [CONN_W-1:0]     conn_mem [N_NEURONS][FANIN];
  logic [FANIN-1:0]      gather;

  always_ff @(posedge clk) begin
    if (lut_we) begin
      lut_mem[lut_n][lut_bit] <= lut_wdat;
    end
    if (conn_we) begin
      conn_mem[conn_n][conn_k] <= conn_wdat;
    end
  end

  // An index past the end of the input vector contributes a 0 address bit.
  always_comb begin
    gather = '0;
    for (int k = 0; k < FANIN; k++) begin
      if (32'(conn_mem[rd_n][k]) < IN_W) begin
        gather[k] = in_vec[conn_mem[rd_n][k]];
      end
    end
  end

  assign res_bit = lut_mem[rd_n][gather];

endmodule

// File: rtl/lut_layer_sequencer.sv
// Time-multiplexed LUT-neuron layer: one neuron per cycle through shared tables (perf counters: LUT_SEQ_PERF_EN).
// Latency: accept at T, out_valid at T+1+N_NEURONS; one vector per N_NEURONS+2 cycles best case.
// Backpressure: result held in DONE until out_ready; no input or config accepted while busy.
module lut_layer_sequencer
  import lut_seq_pkg::*;
#(
  parameter int IN_W      = 64,
  parameter int N_NEURONS = 16,
  parameter int FANIN     = 8,
  parameter int CONN_W    = conn_w(IN_W),
  parameter int NIDX_W    = nidx_w(N_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_NEURONS-1:0]    out_data,
  input  logic                    cfg_we,
  input  logic                    cfg_sel,
  input  logic [NIDX_W+FANIN-1:0] cfg_addr,
  input  logic [CONN_W-1:0]       cfg_wdata,
  output logic                    cfg_ready,
  output logic                    busy
`ifdef LUT_SEQ_PERF_EN
  ,
  output logic [31:0]             perf_vectors,
  output logic [31:0]             perf_stall
`endif
);

  localparam int K_W = clog2_min1(FANIN);
  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] EVAL = ST_EVAL;
  localparam logic [1:0] DONE = ST_DONE;
  localparam logic [NIDX_W-1:0] LAST = NIDX_W'(N_NEURONS - 1);

  logic [1:0]           state;
  logic [NIDX_W-1:0]    cnt;
  logic [IN_W-1:0]      in_reg;
  logic [N_NEURONS-1:0] res;
  logic                 res_bit;
  logic                 cfg_fire;

  assign in_ready  = (state == IDLE);
  assign cfg_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign out_data  = res;
  assign cfg_fire  = cfg_we && cfg_ready;

  lut_seq_mem #(
    .IN_W      (IN_W),
    .N_NEURONS (N_NEURONS),
    .FANIN     (FANIN),
    .CONN_W    (CONN_W),
    .NIDX_W    (NIDX_W),
    .K_W       (K_W)
  ) u_mem (
    .clk       (clk),
    .lut_we    (cfg_fire && (cfg_sel == CFG_SEL_LUT)),
    .lut_n     (cfg_addr[NIDX_W+FANIN-1 -: NIDX_W]),
    .lut_bit   (cfg_addr[FANIN-1:0]),
    .lut_wdat  (cfg_wdata[0]),
    .conn_we   (cfg_fire && (cfg_sel == CFG_SEL_CONN)),
    .conn_n    (cfg_addr[NIDX_W+K_W-1 -: NIDX_W]),
    .conn_k    (cfg_addr[K_W-1:0]),
    .conn_wdat (cfg_wdata),
    .rd_n      (cnt),
    .in_vec    (in_reg),
    .res_bit   (res_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      in_reg <= '0;
      res    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_reg <= in_data;
            cnt    <= '0;
            state  <= EVAL;
          end
        end
        EVAL: begin
          res[cnt] <= res_bit;
          if (cnt == LAST) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LUT_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_vectors <= '0;
      perf_stall   <= '0;
    end else begin
      if (out_valid && out_ready) begin
        perf_vectors <= perf_vectors + 32'd1;
      end
      if (out_valid && !out_ready) begin
        perf_stall <= perf_stall + 32'd1;
      end
    end
  end
`endif

endmodule
